// File: rtl/tanimoto_pkg.sv
// Shared sizing, result layout, FSM states and popcount helper for the
// Tanimoto screening block.
package tanimoto_pkg;

    localparam int VECTOR_WIDTH   = 920;
    localparam int BUS_WIDTH      = 64;
    localparam int CNT_WIDTH      = $clog2(VECTOR_WIDTH);
    localparam int BEATS          = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int BEAT_CNT_WIDTH = $clog2(BEATS);
    localparam int LAST_BITS      = VECTOR_WIDTH - (BEATS - 1) * BUS_WIDTH;
    localparam int REF_WIDTH      = BEATS * BUS_WIDTH;

    localparam int RESULT_WIDTH = 32;
    localparam int MATCH_BIT    = 31;
    localparam int ID_LSB       = 20;
    localparam int BCNT_LSB     = 10;
    localparam int C_LSB        = 0;

    localparam logic [BUS_WIDTH-1:0] LAST_BEAT_MASK =
        {{(BUS_WIDTH - LAST_BITS){1'b0}}, {LAST_BITS{1'b1}}};

    typedef enum logic [1:0] {
        ST_LOAD_REF,
        ST_COMPARE,
        ST_LOOKUP,
        ST_EMIT
    } state_e;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [BUS_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            n = n + CNT_WIDTH'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tanimoto_axis_if.sv
// AXI4-Stream bundle used for both the fingerprint input and the result output.
interface tanimoto_axis_if #(parameter int DATA_WIDTH = 64);

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/threshold_ram.sv
// Threshold table: host write on port A, internal 1-cycle read on port B.
module threshold_ram
    import tanimoto_pkg::*;
(
    input  logic                 clk,
    input  logic                 a_en,
    input  logic                 a_we,
    input  logic [CNT_WIDTH-1:0] a_addr,
    input  logic [CNT_WIDTH-1:0] a_wdata,
    input  logic                 b_en,
    input  logic [CNT_WIDTH-1:0] b_addr,
    output logic [CNT_WIDTH-1:0] b_rdata
);

    logic [CNT_WIDTH-1:0] mem_q [2**CNT_WIDTH];
    logic [CNT_WIDTH-1:0] rd_q;
    logic [CNT_WIDTH-1:0] rd_d;

    // Read data holds between reads; a same-address write shows up only on the next read.
    always_comb begin
        rd_d = rd_q;
        if (b_en) begin
            rd_d = mem_q[b_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            mem_q[a_addr] <= a_wdata;
        end
        rd_q <= rd_d;
    end

    assign b_rdata = rd_q;

endmodule

// File: rtl/tanimoto_accel_system.sv
// Streams fingerprints, keeps the first one as reference and emits one
// match/popcount result beat per following candidate.
module tanimoto_accel_system
    import tanimoto_pkg::*;
(
    input  logic                 aclk_0,
    input  logic                 areset_0,
    tanimoto_axis_if.slave       s_axis,
    tanimoto_axis_if.master      m_axis,
    input  logic [CNT_WIDTH-1:0] BRAM_PORTA_addr_a_0,
    input  logic [CNT_WIDTH-1:0] BRAM_PORTA_wrdata_a_0,
    input  logic                 BRAM_PORTA_en_a_0,
    input  logic                 BRAM_PORTA_we_a_0
);

    state_e                    state_q, state_d;
    logic [BEAT_CNT_WIDTH-1:0] beat_q, beat_d;
    logic [REF_WIDTH-1:0]      a_q, a_d;
    logic [CNT_WIDTH-1:0]      b_cnt_q, b_cnt_d;
    logic [CNT_WIDTH-1:0]      c_q, c_d;
    logic [CNT_WIDTH-1:0]      id_q, id_d;

    logic                      s_ready;
    logic                      beat_last;
    logic                      beat_fire;
    logic                      vec_end;
    logic [BUS_WIDTH-1:0]      beat_data;
    logic [BUS_WIDTH-1:0]      ref_slice;
    int                        slice_base;
    logic [CNT_WIDTH-1:0]      thr_rdata;
    logic [RESULT_WIDTH-1:0]   result;

    threshold_ram u_thr_ram (
        .clk     (aclk_0),
        .a_en    (BRAM_PORTA_en_a_0),
        .a_we    (BRAM_PORTA_we_a_0),
        .a_addr  (BRAM_PORTA_addr_a_0),
        .a_wdata (BRAM_PORTA_wrdata_a_0),
        .b_en    (state_q == ST_LOOKUP),
        .b_addr  (b_cnt_q),
        .b_rdata (thr_rdata)
    );

    assign s_ready    = (state_q == ST_LOAD_REF) || (state_q == ST_COMPARE);
    assign beat_last  = (beat_q == BEAT_CNT_WIDTH'(BEATS - 1));
    assign beat_fire  = s_axis.tvalid && s_ready;
    assign vec_end    = beat_fire && (s_axis.tlast || beat_last);
    assign beat_data  = s_axis.tdata & (beat_last ? LAST_BEAT_MASK : {BUS_WIDTH{1'b1}});
    assign slice_base = int'(beat_q) * BUS_WIDTH;
    assign ref_slice  = a_q[slice_base +: BUS_WIDTH];

    // A vector closes on tlast or on the final beat, whichever comes first;
    // unwritten reference slices stay zero because reset clears the register.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_cnt_d = b_cnt_q;
        c_d     = c_q;
        id_d    = id_q;
        unique case (state_q)
            ST_LOAD_REF: begin
                if (beat_fire) begin
                    a_d[slice_base +: BUS_WIDTH] = beat_data;
                    beat_d = beat_q + 1'b1;
                end
                if (vec_end) begin
                    beat_d  = '0;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (beat_fire) begin
                    b_cnt_d = b_cnt_q + popcount(beat_data);
                    c_d     = c_q + popcount(beat_data & ref_slice);
                    beat_d  = beat_q + 1'b1;
                end
                if (vec_end) begin
                    beat_d  = '0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (m_axis.tready) begin
                    id_d    = id_q + 1'b1;
                    b_cnt_d = '0;
                    c_d     = '0;
                    state_d = ST_COMPARE;
                end
            end
            default: state_d = ST_LOAD_REF;
        endcase
    end

    always_ff @(posedge aclk_0) begin
        if (areset_0) begin
            state_q <= ST_LOAD_REF;
            beat_q  <= '0;
            a_q     <= '0;
            b_cnt_q <= '0;
            c_q     <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_cnt_q <= b_cnt_d;
            c_q     <= c_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        result = '0;
        if (state_q == ST_EMIT) begin
            result[MATCH_BIT]               = (c_q >= thr_rdata);
            result[ID_LSB   +: CNT_WIDTH]   = id_q;
            result[BCNT_LSB +: CNT_WIDTH]   = b_cnt_q;
            result[C_LSB    +: CNT_WIDTH]   = c_q;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = result;
    assign m_axis.tvalid = (state_q == ST_EMIT);
    assign m_axis.tlast  = (state_q == ST_EMIT);

endmodule

// File: tb/tb_tanimoto_accel_system.sv
// Scoreboard bench for tanimoto_accel_system: expected beats are queued as
// vectors are sent and compared when the result handshake happens.
module tb_tanimoto_accel_system;
    import tanimoto_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tanimoto_axis_if #(.DATA_WIDTH(BUS_WIDTH)) s_if ();
    tanimoto_axis_if #(.DATA_WIDTH(32))        m_if ();

    logic [CNT_WIDTH-1:0] bram_addr   = '0;
    logic [CNT_WIDTH-1:0] bram_wrdata = '0;
    logic                 bram_en     = 1'b0;
    logic                 bram_we     = 1'b0;
    logic                 m_ready     = 1'b1;
    int                   ready_mode  = 0;
    int                   cyc         = 0;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];
    logic [919:0] ref_vec = '0;
    int          thr_model[1024];
    int          exp_id = 0;

    tanimoto_accel_system dut (
        .aclk_0               (clk),
        .areset_0             (rst),
        .s_axis               (s_if),
        .m_axis               (m_if),
        .BRAM_PORTA_addr_a_0  (bram_addr),
        .BRAM_PORTA_wrdata_a_0(bram_wrdata),
        .BRAM_PORTA_en_a_0    (bram_en),
        .BRAM_PORTA_we_a_0    (bram_we)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Sink readiness: 0 = always ready, 1 = low 2 of every 8 cycles, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 8) >= 2);
            default: m_ready = 1'b0;
        endcase
    end
    assign m_if.tready = m_ready;

    function automatic logic [959:0] ones_range(input int lo, input int hi);
        logic [959:0] v;
        v = '0;
        for (int i = lo; i < hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [959:0] rand_vec();
        logic [959:0] v;
        for (int w = 0; w < BEATS; w++) v[w*BUS_WIDTH +: BUS_WIDTH] = {$urandom, $urandom};
        return v;
    endfunction

    function automatic logic [919:0] framed(input logic [959:0] v, input int nbeats);
        logic [919:0] b;
        b = v[919:0];
        for (int i = nbeats * BUS_WIDTH; i < 920; i++) b[i] = 1'b0;
        return b;
    endfunction

    function automatic logic [31:0] model_result(input logic [959:0] v, input int nbeats);
        logic [919:0] b;
        int bc, c;
        b  = framed(v, nbeats);
        bc = $countones(b);
        c  = $countones(b & ref_vec);
        return {(c >= thr_model[bc]), 1'b0, 10'(exp_id), 10'(bc), 10'(c)};
    endfunction

    // kind: 0 reference, 1 candidate (model expectation), 2 discarded partial,
    // 3 candidate whose expectation the caller already queued.
    task automatic send_vector(input logic [959:0] v, input int nbeats, input bit with_tlast, input int kind);
        bit hs;
        int guard;
        if (kind == 0) ref_vec = framed(v, nbeats);
        if (kind == 1) sb.push_back(model_result(v, nbeats));
        if (kind == 1 || kind == 3) exp_id++;
        for (int b = 0; b < nbeats; b++) begin
            s_if.tdata  = v[b*BUS_WIDTH +: BUS_WIDTH];
            s_if.tvalid = 1'b1;
            s_if.tlast  = with_tlast && (b == nbeats - 1);
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 100) begin
                @(negedge clk);
                hs = s_if.tready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!hs) begin
                total++;
                bad++;
                $display("[TB] FAIL send_beat: beat %0d not accepted, tready got 0 wanted 1", b);
                break;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic get_result(output logic [31:0] d, output int lat, output bit ok);
        int start;
        int first;
        start = cyc;
        first = -1;
        ok = 1'b0;
        d = '0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (m_if.tvalid && first < 0) first = cyc;
            if (m_if.tvalid && m_if.tready) begin
                d  = m_if.tdata;
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        lat = (first < 0) ? -1 : first - start + 1;
    endtask

    task automatic apply_reset();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_id = 0;
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 1024; k++) begin
            bram_en     = 1'b1;
            bram_we     = 1'b1;
            bram_addr   = CNT_WIDTH'(k);
            bram_wrdata = CNT_WIDTH'(k);
            thr_model[k] = k % 1024;
            @(posedge clk);
            #1;
        end
        bram_en = 1'b0;
        bram_we = 1'b0;
        @(negedge clk);
        total++;
        if (m_if.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid: got %b wanted 0", m_if.tvalid); end
        total++;
        if (m_if.tdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_tdata: got %h wanted 00000000", m_if.tdata); end
        total++;
        if (s_if.tready !== 1'b1) begin bad++; $display("[TB] FAIL reset_s_tready: got %b wanted 1", s_if.tready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_id = 0;
    endtask

    task automatic test_all_ones();
        logic [959:0] v;
        logic [31:0]  d, exp;
        int lat;
        bit ok, seen;
        v = ones_range(0, 960);
        send_vector(v, BEATS, 1'b1, 0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_if.tvalid) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        total++;
        if (seen !== 1'b0) begin bad++; $display("[TB] FAIL ref_no_result: tvalid seen got %b wanted 0", seen); end
        sb.push_back({1'b1, 1'b0, 10'd0, 10'd920, 10'd920});
        send_vector(v, BEATS, 1'b1, 3);
        get_result(d, lat, ok);
        exp = sb.pop_front();
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL all_ones: no result beat, wanted %h", exp); end
        else if (d !== exp) begin bad++; $display("[TB] FAIL all_ones: tdata got %h wanted %h", d, exp); end
        total++;
        if (lat !== 2) begin bad++; $display("[TB] FAIL latency: cycles got %0d wanted 2", lat); end
    endtask

    task automatic test_partial();
        logic [959:0] vecs[3];
        logic [31:0]  exps[3];
        logic [31:0]  d, exp;
        int lat;
        bit ok;
        apply_reset();
        send_vector(ones_range(0, 100), BEATS, 1'b1, 0);
        vecs[0] = ones_range(0, 200);
        exps[0] = {1'b0, 1'b0, 10'd0, 10'd200, 10'd100};
        vecs[1] = ones_range(0, 50);
        exps[1] = {1'b1, 1'b0, 10'd1, 10'd50, 10'd50};
        vecs[2] = ones_range(0, 10) | ones_range(920, 960);
        exps[2] = {1'b1, 1'b0, 10'd2, 10'd10, 10'd10};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exps[i]);
            send_vector(vecs[i], BEATS, 1'b1, 3);
            get_result(d, lat, ok);
            exp = sb.pop_front();
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL partial_%0d: no result beat, wanted %h", i, exp); end
            else if (d !== exp) begin bad++; $display("[TB] FAIL partial_%0d: tdata got %h wanted %h", i, d, exp); end
        end
    endtask

    task automatic test_framing();
        logic [959:0] vecs[3];
        int           nb[3];
        bit           tl[3];
        logic [31:0]  d, exp;
        int lat;
        bit ok;
        vecs[0] = ones_range(0, 960);  nb[0] = 3;     tl[0] = 1'b1;
        vecs[1] = ones_range(0, 60);   nb[1] = BEATS; tl[1] = 1'b0;
        vecs[2] = ones_range(0, 100);  nb[2] = BEATS; tl[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_vector(vecs[i], nb[i], tl[i], 1);
            get_result(d, lat, ok);
            exp = sb.pop_front();
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL framing_%0d: no result beat, wanted %h", i, exp); end
            else if (d !== exp) begin bad++; $display("[TB] FAIL framing_%0d: tdata got %h wanted %h", i, d, exp); end
        end
    endtask

    task automatic test_threshold_rewrite();
        logic [31:0] d, exp;
        int lat;
        bit ok;
        bram_en     = 1'b1;
        bram_we     = 1'b1;
        bram_addr   = CNT_WIDTH'(50);
        bram_wrdata = CNT_WIDTH'(51);
        thr_model[50] = 51;
        @(posedge clk);
        #1;
        bram_en = 1'b0;
        bram_we = 1'b0;
        sb.push_back({1'b0, 1'b0, 10'(exp_id), 10'd50, 10'd50});
        send_vector(ones_range(0, 50), BEATS, 1'b1, 3);
        get_result(d, lat, ok);
        exp = sb.pop_front();
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL thr_rewrite: no result beat, wanted %h", exp); end
        else if (d !== exp) begin bad++; $display("[TB] FAIL thr_rewrite: tdata got %h wanted %h", d, exp); end
    endtask

    task automatic test_back_to_back();
        bit got;
        apply_reset();
        send_vector(rand_vec(), BEATS, 1'b1, 0);
        ready_mode = 1;
        for (int n = 0; n < 100; n++) begin
            send_vector(rand_vec(), BEATS, 1'b1, 1);
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if (m_if.tvalid) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL b2b_extra: unexpected beat %h, wanted none", m_if.tdata);
                    end else if (m_if.tdata !== sb[0]) begin
                        bad++;
                        $display("[TB] FAIL b2b_%0d: tdata got %h wanted %h (tready=%b)", n, m_if.tdata, sb[0], m_if.tready);
                    end
                    if (m_if.tready) begin
                        if (sb.size() > 0) sb.pop_front();
                        got = 1'b1;
                    end
                end
            end
            if (!got) begin
                total++;
                bad++;
                $display("[TB] FAIL b2b_%0d: no result beat, got none wanted 1", n);
            end
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        total++;
        if (sb.size() !== 0) begin bad++; $display("[TB] FAIL b2b_leftover: queue size got %0d wanted 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, exp;
        int lat;
        bit ok, seen;
        apply_reset();
        send_vector(rand_vec(), BEATS, 1'b1, 0);
        send_vector(rand_vec(), 5, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (m_if.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_vec_tvalid: got %b wanted 0", m_if.tvalid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_id = 0;
        send_vector(ones_range(0, 300), BEATS, 1'b1, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (m_if.tvalid) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        total++;
        if (seen !== 1'b0) begin bad++; $display("[TB] FAIL rst_new_ref: tvalid seen got %b wanted 0", seen); end
        send_vector(rand_vec(), BEATS, 1'b1, 1);
        get_result(d, lat, ok);
        exp = sb.pop_front();
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL rst_new_ref_cand: no result beat, wanted %h", exp); end
        else if (d !== exp) begin bad++; $display("[TB] FAIL rst_new_ref_cand: tdata got %h wanted %h", d, exp); end

        ready_mode = 2;
        send_vector(rand_vec(), BEATS, 1'b1, 1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (m_if.tvalid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b1) begin bad++; $display("[TB] FAIL emit_stall: tvalid got %b wanted 1", seen); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (m_if.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_emit_tvalid: got %b wanted 0", m_if.tvalid); end
        total++;
        if (m_if.tdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_mid_emit_tdata: got %h wanted 00000000", m_if.tdata); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_id = 0;
        ready_mode = 0;
        send_vector(ones_range(100, 400), BEATS, 1'b1, 0);
        send_vector(ones_range(0, 200), BEATS, 1'b1, 1);
        get_result(d, lat, ok);
        exp = sb.pop_front();
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL rst_emit_next: no result beat, wanted %h", exp); end
        else if (d !== exp) begin bad++; $display("[TB] FAIL rst_emit_next: tdata got %h wanted %h", d, exp); end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        test_reset();
        test_all_ones();
        test_partial();
        test_framing();
        test_threshold_rewrite();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation still running, got timeout wanted finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
